// File: rtl/unary_pulse_accumulator.sv
// Sums unary pulse trains from NUM_LANES product blocks over one accumulation window
// and returns {sum, fire, ovf} on a valid/ready handshake. Optional: ACC_SATURATE_EN.
module unary_pulse_accumulator #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned ACC_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [NUM_LANES-1:0] lane_pulse,
    input  logic [NUM_LANES-1:0] lane_busy,
    input  logic [ACC_WIDTH-1:0] thresh,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_fire,
    output logic                 out_ovf
);

    localparam int unsigned CntWidth = $clog2(NUM_LANES + 1);
    localparam int unsigned ExtWidth = ACC_WIDTH + 1;

    typedef enum logic [1:0] {
        StIdle,
        StGrace,
        StAccum,
        StHold
    } state_e;

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] thresh_q, thresh_d;
    logic [ACC_WIDTH-1:0] sum_q, sum_d;
    logic                 valid_q, valid_d;
    logic                 fire_q, fire_d;
    logic                 ovf_q, ovf_d;

    logic [CntWidth-1:0]  pop_cnt;
    logic [ExtWidth-1:0]  sum_ext;
    logic                 add_ovf;
    logic [ACC_WIDTH-1:0] acc_next;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            pop_cnt = pop_cnt + CntWidth'(lane_pulse[i]);
        end
    end

    // One extra bit catches the carry out of the accumulator.
    assign sum_ext = {1'b0, acc_q} + ExtWidth'(pop_cnt);
    assign add_ovf = sum_ext[ACC_WIDTH];

`ifdef ACC_SATURATE_EN
    assign acc_next = add_ovf ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
`else
    assign acc_next = sum_ext[ACC_WIDTH-1:0];
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        thresh_d = thresh_q;
        sum_d    = sum_q;
        valid_d  = valid_q;
        fire_d   = fire_q;
        ovf_d    = ovf_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d    = '0;
                    ovf_d    = 1'b0;
                    thresh_d = thresh;
                    state_d  = StGrace;
                end
            end
            StGrace: begin
                // Busy is not yet meaningful here: upstream needs a cycle to raise it.
                acc_d   = acc_next;
                ovf_d   = ovf_q | add_ovf;
                state_d = StAccum;
            end
            StAccum: begin
                acc_d = acc_next;
                ovf_d = ovf_q | add_ovf;
                if (lane_busy == '0) begin
                    sum_d   = acc_next;
                    fire_d  = (acc_next >= thresh_q);
                    valid_d = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            thresh_q <= '0;
            sum_q    <= '0;
            valid_q  <= 1'b0;
            fire_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            thresh_q <= thresh_d;
            sum_q    <= sum_d;
            valid_q  <= valid_d;
            fire_q   <= fire_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_fire  = fire_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_unary_pulse_accumulator.sv
// Scoreboard bench: a 10-bit and a 4-bit accumulator see identical stimulus; expected
// results are modelled when a window is driven and compared when out_valid rises.
module tb_unary_pulse_accumulator;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] lane_pulse;
    logic [3:0] lane_busy;
    logic [9:0] thresh;
    logic [3:0] thresh4;
    logic       out_ready;

    logic       out_valid, out_fire, out_ovf;
    logic [9:0] out_sum;
    logic       w4_valid, w4_fire, w4_ovf;
    logic [3:0] w4_sum;

    assign thresh4 = thresh[3:0];

    unary_pulse_accumulator #(.NUM_LANES(4), .ACC_WIDTH(10)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .lane_pulse (lane_pulse),
        .lane_busy  (lane_busy),
        .thresh     (thresh),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_fire   (out_fire),
        .out_ovf    (out_ovf)
    );

    unary_pulse_accumulator #(.NUM_LANES(4), .ACC_WIDTH(4)) dut_w4 (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .lane_pulse (lane_pulse),
        .lane_busy  (lane_busy),
        .thresh     (thresh4),
        .out_valid  (w4_valid),
        .out_ready  (out_ready),
        .out_sum    (w4_sum),
        .out_fire   (w4_fire),
        .out_ovf    (w4_ovf)
    );

    typedef struct {
        logic [9:0] sum;
        logic       fire;
        logic       ovf;
        logic [3:0] sum4;
        logic       fire4;
        logic       ovf4;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one window: IDLE start cycle, GRACE, ACCUM cycles, then HOLD for
    // hold_cycles of backpressure before the handshake. Ends on a negedge in IDLE.
    task automatic run_window(input logic [9:0] th, input int c0, input int c1,
                              input int c2, input int c3, input int extra,
                              input int hold_cycles, input bit poke);
        int         cnt[4];
        int         n;
        int         pc;
        int         total;
        int         waited;
        logic [4:0] s4;
        logic [3:0] a4;
        exp_t       e;
        cnt = '{c0, c1, c2, c3};
        n = 0;
        for (int i = 0; i < 4; i++) if (cnt[i] > n) n = cnt[i];
        n = n + extra;
        if (n < 2) n = 2;
        total = 0;
        a4 = 4'd0;
        e.ovf4 = 1'b0;
        for (int k = 0; k < n; k++) begin
            pc = 0;
            for (int i = 0; i < 4; i++) if (k < cnt[i]) pc++;
            total += pc;
            s4 = {1'b0, a4} + 5'(pc);
            if (s4[4]) begin
                e.ovf4 = 1'b1;
`ifdef ACC_SATURATE_EN
                a4 = 4'hf;
`else
                a4 = s4[3:0];
`endif
            end else begin
                a4 = s4[3:0];
            end
        end
        e.sum   = 10'(total);
        e.fire  = (10'(total) >= th);
        e.ovf   = 1'b0;
        e.sum4  = a4;
        e.fire4 = (a4 >= th[3:0]);
        sb_q.push_back(e);

        start      = 1'b1;
        thresh     = th;
        lane_pulse = 4'($urandom);
        lane_busy  = 4'($urandom);
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            start     = poke && (k >= 1);
            thresh    = poke ? ~th : th;
            lane_busy = (k == 0 || k == n - 1) ? 4'b0000 : 4'b1111;
            for (int i = 0; i < 4; i++) lane_pulse[i] = (k < cnt[i]);
            @(negedge clk);
        end
        start      = poke;
        lane_busy  = 4'b0000;
        lane_pulse = 4'($urandom);

        waited = 0;
        while (out_valid !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        tests_run++;
        if (waited != 0) begin
            tests_failed++;
            $display("FAIL latency: out_valid after %0d extra cycles, required 0", waited);
        end

        e = sb_q.pop_front();
        tests_run += 6;
        if (out_sum !== e.sum) begin
            tests_failed++;
            $display("FAIL sum: got %0d, required %0d", out_sum, e.sum);
        end
        if (out_fire !== e.fire) begin
            tests_failed++;
            $display("FAIL fire: got %b, required %b", out_fire, e.fire);
        end
        if (out_ovf !== e.ovf) begin
            tests_failed++;
            $display("FAIL ovf: got %b, required %b", out_ovf, e.ovf);
        end
        if (w4_sum !== e.sum4) begin
            tests_failed++;
            $display("FAIL w4_sum: got %0d, required %0d", w4_sum, e.sum4);
        end
        if (w4_fire !== e.fire4) begin
            tests_failed++;
            $display("FAIL w4_fire: got %b, required %b", w4_fire, e.fire4);
        end
        if (w4_ovf !== e.ovf4) begin
            tests_failed++;
            $display("FAIL w4_ovf: got %b, required %b", w4_ovf, e.ovf4);
        end

        for (int h = 0; h < hold_cycles; h++) begin
            out_ready  = 1'b0;
            lane_pulse = 4'($urandom);
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || out_sum !== e.sum || out_fire !== e.fire) begin
                tests_failed++;
                $display("FAIL hold_stable: valid=%b sum=%0d fire=%b, required 1/%0d/%b",
                         out_valid, out_sum, out_fire, e.sum, e.fire);
            end
        end

        out_ready  = 1'b1;
        start      = 1'b0;
        lane_pulse = 4'($urandom);
        @(negedge clk);
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || w4_valid !== 1'b0 || out_sum !== e.sum) begin
            tests_failed++;
            $display("FAIL handshake: valid=%b w4_valid=%b sum=%0d, required 0/0/%0d",
                     out_valid, w4_valid, out_sum, e.sum);
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if ({out_valid, out_sum, out_fire, out_ovf} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_w10: valid=%b sum=%0d fire=%b ovf=%b, required all 0",
                     out_valid, out_sum, out_fire, out_ovf);
        end
        tests_run++;
        if ({w4_valid, w4_sum, w4_fire, w4_ovf} !== 7'd0) begin
            tests_failed++;
            $display("FAIL reset_w4: valid=%b sum=%0d fire=%b ovf=%b, required all 0",
                     w4_valid, w4_sum, w4_fire, w4_ovf);
        end
    endtask

    task automatic test_single_lane();
        run_window(10'd6, 6, 0, 0, 0, 1, 3, 1'b0);
    endtask

    task automatic test_four_lanes();
        run_window(10'd16, 3, 5, 0, 7, 1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_window(10'd10, 4, 4, 2, 1, 2, 10, 1'b0);
    endtask

    task automatic test_overflow();
        run_window(10'd7, 5, 5, 5, 5, 1, 1, 1'b0);
    endtask

    task automatic test_ignored_start();
        run_window(10'd20, 2, 3, 4, 1, 3, 4, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_window(10'd1, 1, 0, 0, 0, 0, 0, 1'b0);
        run_window(10'd0, 0, 0, 0, 0, 0, 0, 1'b0);
        run_window(10'd9, 2, 2, 3, 3, 0, 2, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            run_window(10'($urandom_range(0, 30)), $urandom_range(0, 8),
                       $urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 8),
                       $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        start  = 1'b1;
        thresh = 10'd3;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            lane_busy  = (k == 0) ? 4'b0000 : 4'b1111;
            lane_pulse = 4'b0001;
            @(negedge clk);
        end
        lane_pulse = 4'b0000;
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, out_sum, out_fire, out_ovf, w4_valid, w4_sum, w4_fire, w4_ovf}
            !== 20'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: valid=%b sum=%0d fire=%b ovf=%b w4_sum=%0d, required 0",
                     out_valid, out_sum, out_fire, out_ovf, w4_sum);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        lane_busy = 4'b0000;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: out_valid=%b, required 0", out_valid);
        end
        run_window(10'd3, 2, 1, 0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        lane_pulse = 4'b0000;
        lane_busy  = 4'b0000;
        thresh     = 10'd0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_single_lane();
        test_four_lanes();
        test_backpressure();
        test_overflow();
        test_ignored_start();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
